// File: rtl/addr_region_router.sv
// addr_region_router
//   Routes a single master request channel to NUM_SLAVES slave ports using
//   per-region base/size parameters. Each slave sees an offset address relative
//   to its region base. A request can only switch to a different slave once
//   every outstanding transaction has drained, so responses always return in
//   order. Addresses outside every region get an internal decode-error response.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_*             master request channel (valid/ready, addr, we, wdata)
//   s_req_valid       per-slave request valid (one-hot or zero)
//   s_req_ready       per-slave ready
//   s_req_addr/we/wdata  shared forwarded request fields (addr is region-relative)
//   s_rsp_valid       per-slave response valid (one per accepted request)
//   s_rsp_rdata       per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   rsp_valid         registered response pulse to the master (no backpressure)
//   rsp_rdata         response data, holds its value between pulses
//   rsp_err           decode-error flag, qualified by rsp_valid
//   spurious_rsp      sticky flag: response from a non-current slave or with nothing outstanding
module addr_region_router #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = {32'h80000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZE = {32'h10000000, 32'h40000000},
  parameter logic [DATA_W-1:0]            ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic                         req_we,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic [NUM_SLAVES-1:0]        s_req_valid,
  input  logic [NUM_SLAVES-1:0]        s_req_ready,
  output logic [ADDR_W-1:0]            s_req_addr,
  output logic                         s_req_we,
  output logic [DATA_W-1:0]            s_req_wdata,
  input  logic [NUM_SLAVES-1:0]        s_rsp_valid,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rsp_rdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         spurious_rsp
);

  localparam int TGT_W = $clog2(NUM_SLAVES + 1);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  // Target index one past the last slave denotes "no region hit".
  localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NUM_SLAVES);

  logic [CNT_W-1:0]  r_cnt;
  logic [TGT_W-1:0]  r_cur_tgt;
  logic              r_err_pend;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_spurious;

  logic [NUM_SLAVES-1:0] w_hit;
  logic [TGT_W-1:0]      w_tgt;
  logic [ADDR_W-1:0]     w_base;
  logic                  w_is_err;
  logic                  w_sel_ready;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_acc_map;
  logic                  w_acc_err;
  logic [NUM_SLAVES-1:0] w_cur_oh;
  logic [DATA_W-1:0]     w_cur_rdata;
  logic                  w_rsp_take;
  logic                  w_spurious;

  // Region compare is done one bit wider than the address so that a region
  // ending exactly at 2^ADDR_W does not wrap to zero.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      localparam logic [ADDR_W:0] BASE_X = {1'b0, REGION_BASE[gi*ADDR_W +: ADDR_W]};
      localparam logic [ADDR_W:0] END_X  = BASE_X + {1'b0, REGION_SIZE[gi*ADDR_W +: ADDR_W]};
      assign w_hit[gi] = ({1'b0, req_addr} >= BASE_X) && ({1'b0, req_addr} < END_X);
    end
  endgenerate

  // Scan from the highest index down so the lowest-index hit is the one left.
  always_comb begin
    w_tgt  = ERR_TGT;
    w_base = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_tgt  = TGT_W'(i);
        w_base = REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_is_err = (w_tgt == ERR_TGT);

  always_comb begin
    w_sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_tgt == TGT_W'(i)) begin
        w_sel_ready = s_req_ready[i];
      end
    end
  end

  // r_cur_tgt never holds ERR_TGT, so the last term is already covered by the
  // ordering term; it is kept to make the error-vs-outstanding rule explicit.
  assign w_stall = (r_cnt == CNT_W'(MAX_OUT))
                 || ((r_cnt != '0) && (w_tgt != r_cur_tgt))
                 || r_err_pend
                 || (w_is_err && (r_cnt != '0));

  assign req_ready = !w_stall && (w_is_err || w_sel_ready);

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sreq
      assign s_req_valid[gi] = req_valid && !w_stall && (w_tgt == TGT_W'(gi));
    end
  endgenerate

  assign s_req_addr  = req_addr - w_base;
  assign s_req_we    = req_we;
  assign s_req_wdata = req_wdata;

  assign w_accept  = req_valid && req_ready;
  assign w_acc_map = w_accept && !w_is_err;
  assign w_acc_err = w_accept && w_is_err;

  always_comb begin
    w_cur_oh    = '0;
    w_cur_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_cur_tgt == TGT_W'(i)) begin
        w_cur_oh[i] = 1'b1;
        w_cur_rdata = s_rsp_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_rsp_take = (|(s_rsp_valid & w_cur_oh)) && (r_cnt != '0);
  assign w_spurious = (|(s_rsp_valid & ~w_cur_oh)) || ((|s_rsp_valid) && (r_cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cur_tgt   <= '0;
      r_err_pend  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      // A mapped response and a pending error can never coincide: an error is
      // only accepted with nothing outstanding, and nothing is accepted while
      // the error is pending.
      if (w_rsp_take) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_cur_rdata;
        r_rsp_err   <= 1'b0;
      end else if (r_err_pend) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= ERR_DATA;
        r_rsp_err   <= 1'b1;
      end

      // The stall while pending blocks a new error accept, so this also clears it.
      r_err_pend <= w_acc_err;

      if (w_acc_map) begin
        r_cur_tgt <= w_tgt;
      end

      case ({w_acc_map, w_rsp_take})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_spurious) begin
        r_spurious <= 1'b1;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign spurious_rsp = r_spurious;

endmodule

// File: tb/tb_addr_region_router.sv
module tb_addr_region_router;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [2:0]  s_req_valid;
  logic [2:0]  s_req_ready;
  logic [31:0] s_req_addr;
  logic        s_req_we;
  logic [31:0] s_req_wdata;
  logic [2:0]  s_rsp_valid;
  logic [95:0] s_rsp_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        spurious_rsp;

  int n_checks = 0;
  int n_errors = 0;

  // Map: slave0 0x00000000..0x3FFFFFFF, slave1 0x80000000..0xCFFFFFFF,
  // slave2 0xC0000000..0xFFFFFFFF (ends at 2^32, overlaps slave1 which wins).
  addr_region_router #(
    .NUM_SLAVES (NS),
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_OUT    (4),
    .REGION_BASE({32'hC0000000, 32'h80000000, 32'h00000000}),
    .REGION_SIZE({32'h40000000, 32'h50000000, 32'h40000000}),
    .ERR_DATA   (32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_req_addr  (s_req_addr),
    .s_req_we    (s_req_we),
    .s_req_wdata (s_req_wdata),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_rdata (s_rsp_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference address map.
  function automatic longint unsigned ref_base(input int i);
    case (i)
      0:       return 64'h0000_0000;
      1:       return 64'h8000_0000;
      default: return 64'hC000_0000;
    endcase
  endfunction

  function automatic longint unsigned ref_size(input int i);
    case (i)
      0:       return 64'h4000_0000;
      1:       return 64'h5000_0000;
      default: return 64'h4000_0000;
    endcase
  endfunction

  function automatic int ref_decode(input logic [31:0] a);
    longint unsigned x = {32'd0, a};
    for (int i = 0; i < NS; i++) begin
      if (x >= ref_base(i) && x < ref_base(i) + ref_size(i)) return i;
    end
    return NS;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0:       return r % 32'h4000_0000;
      1:       return 32'h8000_0000 + (r % 32'h5000_0000);
      2:       return 32'hC000_0000 + (r % 32'h4000_0000);
      3:       return 32'h4000_0000 + (r % 32'h4000_0000);
      4:       return r;
      default: begin
        case ($urandom_range(0, 5))
          0:       return 32'h3FFF_FFFF;
          1:       return 32'h4000_0000;
          2:       return 32'h7FFF_FFFF;
          3:       return 32'hCFFF_FFFF;
          4:       return 32'hD000_0000;
          default: return 32'hFFFF_FFFF;
        endcase
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid   = 1'b0;
    req_addr    = 32'h0;
    req_we      = 1'b0;
    req_wdata   = 32'h0;
    s_req_ready = 3'b111;
    s_rsp_valid = 3'b000;
    s_rsp_rdata = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if (spurious_rsp !== 1'b0) begin n_errors++; $display("FAIL reset_spurious: got %b want 0", spurious_rsp); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (s_req_valid !== 3'b000) begin n_errors++; $display("FAIL reset_s_req_valid: got %b want 000", s_req_valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic_read();
    idle();
    req_valid = 1'b1; req_addr = 32'h0000_1000; req_we = 1'b0;
    #1;
    n_checks++; if (s_req_valid !== 3'b001) begin n_errors++; $display("FAIL basic_s_req_valid: got %b want 001", s_req_valid); end
    n_checks++; if (s_req_addr !== 32'h0000_1000) begin n_errors++; $display("FAIL basic_s_req_addr: got %h want 00001000", s_req_addr); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL basic_req_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_rsp c%0d: got %b want 0", k, rsp_valid); end
      tick();
    end
    s_rsp_valid = 3'b001; s_rsp_rdata[31:0] = 32'h1234_5678;
    tick();
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL basic_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL basic_rsp_rdata: got %h want 12345678", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL basic_rsp_err: got %b want 0", rsp_err); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL basic_rsp_pulse: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL basic_rdata_hold: got %h want 12345678", rsp_rdata); end
    $display("test_basic_read done: read 00001000 -> 12345678");
  endtask

  task automatic test_ordering();
    idle();
    req_valid = 1'b1; req_addr = 32'h8000_0010;
    #1;
    n_checks++; if (s_req_valid !== 3'b010) begin n_errors++; $display("FAIL ord_s_req_valid: got %b want 010", s_req_valid); end
    n_checks++; if (s_req_addr !== 32'h0000_0010) begin n_errors++; $display("FAIL ord_s_req_addr: got %h want 00000010", s_req_addr); end
    tick();
    req_addr = 32'h0000_0000;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL ord_stall: got %b want 0", req_ready); end
    n_checks++; if (s_req_valid !== 3'b000) begin n_errors++; $display("FAIL ord_stall_valid: got %b want 000", s_req_valid); end
    tick();
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL ord_stall2: got %b want 0", req_ready); end
    s_rsp_valid = 3'b010; s_rsp_rdata[63:32] = 32'hA5A5_0001;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL ord_stall_rspcyc: got %b want 0", req_ready); end
    tick();
    s_rsp_valid = 3'b000;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001) begin n_errors++; $display("FAIL ord_rsp1: got v=%b d=%h want v=1 d=a5a50001", rsp_valid, rsp_rdata); end
    n_checks++; if (req_ready !== 1'b1 || s_req_valid !== 3'b001) begin n_errors++; $display("FAIL ord_release: got rdy=%b sv=%b want rdy=1 sv=001", req_ready, s_req_valid); end
    tick();
    // slave0 now has one outstanding; an unmapped request must also wait
    req_addr = 32'h5000_0000;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL ord_err_stall: got %b want 0", req_ready); end
    req_valid = 1'b0;
    s_rsp_valid = 3'b001; s_rsp_rdata[31:0] = 32'h0BAD_F00D;
    tick();
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL ord_rsp2: got v=%b d=%h want v=1 d=0badf00d", rsp_valid, rsp_rdata); end
    $display("test_ordering done");
  endtask

  task automatic test_decode_error();
    idle();
    req_valid = 1'b1; req_addr = 32'h5000_0000;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL err_ready: got %b want 1", req_ready); end
    n_checks++; if (s_req_valid !== 3'b000) begin n_errors++; $display("FAIL err_no_fwd: got %b want 000", s_req_valid); end
    tick();
    // back-to-back unmapped requests: one accept every two cycles
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6);
      req_we    = k[0];
      req_addr  = 32'h4000_0000 + 32'(k) * 32'h0100_0000;
      #1;
      n_checks++; if (req_ready !== k[0]) begin n_errors++; $display("FAIL err_b2b_ready k%0d: got %b want %b", k, req_ready, k[0]); end
      n_checks++; if (rsp_valid !== k[0]) begin n_errors++; $display("FAIL err_b2b_rsp k%0d: got %b want %b", k, rsp_valid, k[0]); end
      if (k[0]) begin
        n_checks++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b1) begin n_errors++; $display("FAIL err_rsp k%0d: got d=%h e=%b want d=deadbeef e=1", k, rsp_rdata, rsp_err); end
      end
      tick();
    end
    $display("test_decode_error done");
  endtask

  task automatic test_max_outstanding();
    idle();
    req_valid = 1'b1; req_we = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_addr = 32'h100 + 32'(k) * 4; req_wdata = 32'(k);
      #1;
      n_checks++; if (req_ready !== (k < 4)) begin n_errors++; $display("FAIL max_ready k%0d: got %b want %b", k, req_ready, (k < 4)); end
      tick();
    end
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL max_held: got %b want 0", req_ready); end
    s_rsp_valid = 3'b001; s_rsp_rdata[31:0] = 32'h0000_1000;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL max_held_rspcyc: got %b want 0", req_ready); end
    tick();
    // slot freed; accept the fifth request together with another response
    s_rsp_rdata[31:0] = 32'h0000_1001;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_1000) begin n_errors++; $display("FAIL max_rsp1: got v=%b d=%h want v=1 d=00001000", rsp_valid, rsp_rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL max_slot_free: got %b want 1", req_ready); end
    tick();
    s_rsp_valid = 3'b000;
    req_addr = 32'h200;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_1001) begin n_errors++; $display("FAIL max_rsp2: got v=%b d=%h want v=1 d=00001001", rsp_valid, rsp_rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL max_simul_cnt: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL max_full_again: got %b want 0", req_ready); end
    for (int k = 0; k < 4; k++) begin
      s_rsp_valid = 3'b001; s_rsp_rdata[31:0] = 32'h2000 + 32'(k);
      tick();
      s_rsp_valid = 3'b000;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2000 + 32'(k)) begin n_errors++; $display("FAIL max_drain k%0d: got v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_rdata, 32'h2000 + 32'(k)); end
    end
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL max_drained: got %b want 1", req_ready); end
    $display("test_max_outstanding done");
  endtask

  task automatic test_spurious();
    idle();
    req_valid = 1'b1; req_addr = 32'h40;
    tick();
    req_valid = 1'b0;
    s_rsp_valid = 3'b010; s_rsp_rdata[63:32] = 32'h6666_6666;
    tick();
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL spur_dropped: got %b want 0", rsp_valid); end
    n_checks++; if (spurious_rsp !== 1'b1) begin n_errors++; $display("FAIL spur_flag: got %b want 1", spurious_rsp); end
    tick();
    n_checks++; if (spurious_rsp !== 1'b1) begin n_errors++; $display("FAIL spur_sticky: got %b want 1", spurious_rsp); end
    s_rsp_valid = 3'b001; s_rsp_rdata[31:0] = 32'h5151_5151;
    tick();
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5151_5151) begin n_errors++; $display("FAIL spur_cnt_kept: got v=%b d=%h want v=1 d=51515151", rsp_valid, rsp_rdata); end
    req_addr = 32'h8000_0000;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL spur_drained: got %b want 1", req_ready); end
    $display("test_spurious done");
  endtask

  task automatic test_reset_mid();
    idle();
    req_valid = 1'b1; req_addr = 32'h0;
    repeat (3) tick();
    req_valid = 1'b0;
    rst = 1'b1;
    s_rsp_valid = 3'b001; s_rsp_rdata[31:0] = 32'h7777_7777;
    tick();
    rst = 1'b0;
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_rsp: got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err); end
    n_checks++; if (spurious_rsp !== 1'b0) begin n_errors++; $display("FAIL rstmid_spurious: got %b want 0", spurious_rsp); end
    req_valid = 1'b1; req_addr = 32'h8000_0004;
    #1;
    n_checks++; if (req_ready !== 1'b1 || s_req_valid !== 3'b010 || s_req_addr !== 32'h4) begin n_errors++; $display("FAIL rstmid_new_req: got rdy=%b sv=%b a=%h want 1/010/00000004", req_ready, s_req_valid, s_req_addr); end
    tick();
    req_valid = 1'b0;
    s_rsp_valid = 3'b010; s_rsp_rdata[63:32] = 32'h8888_8888;
    tick();
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8888_8888) begin n_errors++; $display("FAIL rstmid_rsp_after: got v=%b d=%h want v=1 d=88888888", rsp_valid, rsp_rdata); end
    // response with nothing outstanding
    s_rsp_valid = 3'b100;
    tick();
    s_rsp_valid = 3'b000;
    n_checks++; if (rsp_valid !== 1'b0 || spurious_rsp !== 1'b1) begin n_errors++; $display("FAIL spur_idle: got v=%b s=%b want v=0 s=1", rsp_valid, spurious_rsp); end
    $display("test_reset_mid done");
  endtask

  task automatic test_decode_map();
    logic [31:0] addrs [9];
    logic [2:0]  exp_sv [9];
    logic [31:0] exp_off [9];
    addrs[0] = 32'h0000_0000; exp_sv[0] = 3'b001; exp_off[0] = 32'h0000_0000;
    addrs[1] = 32'h3FFF_FFFF; exp_sv[1] = 3'b001; exp_off[1] = 32'h3FFF_FFFF;
    addrs[2] = 32'h4000_0000; exp_sv[2] = 3'b000; exp_off[2] = 32'h0;
    addrs[3] = 32'h7FFF_FFFF; exp_sv[3] = 3'b000; exp_off[3] = 32'h0;
    addrs[4] = 32'h8000_0000; exp_sv[4] = 3'b010; exp_off[4] = 32'h0000_0000;
    addrs[5] = 32'hC800_0000; exp_sv[5] = 3'b010; exp_off[5] = 32'h4800_0000;
    addrs[6] = 32'hCFFF_FFFF; exp_sv[6] = 3'b010; exp_off[6] = 32'h4FFF_FFFF;
    addrs[7] = 32'hD000_0000; exp_sv[7] = 3'b100; exp_off[7] = 32'h1000_0000;
    addrs[8] = 32'hFFFF_FFFF; exp_sv[8] = 3'b100; exp_off[8] = 32'h3FFF_FFFF;
    idle();
    for (int i = 0; i < 9; i++) begin
      tick();
      req_valid = 1'b1; req_addr = addrs[i]; req_we = i[0]; req_wdata = 32'hC0DE_0000 + 32'(i);
      #1;
      n_checks++; if (s_req_valid !== exp_sv[i]) begin n_errors++; $display("FAIL map_valid %h: got %b want %b", addrs[i], s_req_valid, exp_sv[i]); end
      if (exp_sv[i] != 3'b000) begin
        n_checks++; if (s_req_addr !== exp_off[i]) begin n_errors++; $display("FAIL map_offset %h: got %h want %h", addrs[i], s_req_addr, exp_off[i]); end
      end
      n_checks++; if (s_req_we !== i[0] || s_req_wdata !== 32'hC0DE_0000 + 32'(i)) begin n_errors++; $display("FAIL map_fwd %h: got we=%b wd=%h", addrs[i], s_req_we, s_req_wdata); end
      req_valid = 1'b0;
    end
    $display("test_decode_map done");
  endtask

  task automatic test_random();
    logic [31:0] pend_q[$];
    int          out_tgt = 0;
    bit          err_p = 1'b0;
    bit          exp_v = 1'b0;
    logic [31:0] exp_d = 32'h0;
    bit          exp_e = 1'b0;
    int          tgt;
    bit          stall;
    bit          exp_rdy;
    logic [2:0]  exp_sv;
    logic [31:0] exp_off;
    int          n_txn = 0;
    idle();
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++; if (rsp_valid !== exp_v) begin n_errors++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (rsp_rdata !== exp_d || rsp_err !== exp_e) begin n_errors++; $display("FAIL rnd_rsp_data c%0d: got d=%h e=%b want d=%h e=%b", cyc, rsp_rdata, rsp_err, exp_d, exp_e); end
      end
      req_valid   = ($urandom_range(0, 3) != 0);
      req_addr    = rand_addr();
      req_we      = 1'($urandom_range(0, 1));
      req_wdata   = $urandom;
      s_req_ready = 3'($urandom_range(0, 7));
      s_rsp_valid = 3'b000;
      s_rsp_rdata = {$urandom, $urandom, $urandom};
      if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        s_rsp_valid[out_tgt] = 1'b1;
        s_rsp_rdata[out_tgt*32 +: 32] = pend_q[0];
      end
      #1;
      tgt     = ref_decode(req_addr);
      stall   = (pend_q.size() == 4) || (pend_q.size() != 0 && tgt != out_tgt) || err_p;
      exp_rdy = !stall && ((tgt == NS) ? 1'b1 : s_req_ready[tgt]);
      exp_sv  = (req_valid && !stall && tgt != NS) ? 3'(1 << tgt) : 3'b000;
      n_checks++; if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL rnd_req_ready c%0d a=%h: got %b want %b", cyc, req_addr, req_ready, exp_rdy); end
      n_checks++; if (s_req_valid !== exp_sv) begin n_errors++; $display("FAIL rnd_s_req_valid c%0d a=%h: got %b want %b", cyc, req_addr, s_req_valid, exp_sv); end
      if (tgt != NS) begin
        exp_off = req_addr - 32'(ref_base(tgt));
        n_checks++; if (s_req_addr !== exp_off) begin n_errors++; $display("FAIL rnd_s_req_addr c%0d a=%h: got %h want %h", cyc, req_addr, s_req_addr, exp_off); end
      end
      @(posedge clk);
      exp_v = 1'b0;
      if (s_rsp_valid != 3'b000) begin
        exp_v = 1'b1; exp_d = pend_q.pop_front(); exp_e = 1'b0;
      end else if (err_p) begin
        exp_v = 1'b1; exp_d = 32'hDEAD_BEEF; exp_e = 1'b1;
      end
      err_p = 1'b0;
      if (req_valid && exp_rdy) begin
        n_txn++;
        if (tgt == NS) begin
          err_p = 1'b1;
        end else begin
          out_tgt = tgt;
          pend_q.push_back($urandom);
        end
        $display("txn %0d: addr=%h we=%b target=%0d", n_txn, req_addr, req_we, tgt);
      end
      #1;
    end
    idle();
    $display("test_random done: %0d transactions", n_txn);
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_ordering();
    test_decode_error();
    test_max_outstanding();
    test_decode_map();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
